// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, stall hold of the fetched word, and branch redirect.
// Optional macro BRANCH_DELAY_SLOT_EN keeps the delay-slot instruction valid on a redirect.
module fetch_stage #(
   parameter logic [31:0] pc_init  = 32'h80020000,
   parameter logic [31:0] nop_word = 32'h00000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] instr_addr,
   input  logic [31:0] instr_in,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc,
   output logic        if_id_valid
);

   localparam int unsigned XLEN = 32;

`ifdef BRANCH_DELAY_SLOT_EN
   localparam logic REDIRECT_VALID = 1'b1;
`else
   localparam logic REDIRECT_VALID = 1'b0;
`endif

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [XLEN-1:0]   r_pc;
   logic [XLEN-1:0]   r_fetch_pc;
   logic              r_fetch_valid;
   logic [XLEN-1:0]   r_hold;
   logic [XLEN-1:0]   w_pc_nxt;
   logic [XLEN-1:0]   w_fetch_pc_nxt;
   logic              w_fetch_valid_nxt;
   logic [XLEN-1:0]   w_hold_nxt;
   logic [XLEN-1:0]   w_pc_inc;
   logic [XLEN-1:0]   w_target;

   // Wraps modulo 2^32 by construction; target is word-aligned by masking the low bits.
   assign w_pc_inc = r_pc + XLEN'(4);
   assign w_target = branch_target & ~XLEN'(3);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_RUN;
         r_pc          <= pc_init;
         r_fetch_pc    <= pc_init;
         r_fetch_valid <= 1'b0;
         r_hold        <= nop_word;
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_fetch_pc    <= w_fetch_pc_nxt;
         r_fetch_valid <= w_fetch_valid_nxt;
         r_hold        <= w_hold_nxt;
      end
   end

   // Next-state logic; a redirect overrides any stall.
   always_comb begin
      w_state_nxt       = r_state;
      w_pc_nxt          = r_pc;
      w_fetch_pc_nxt    = r_fetch_pc;
      w_fetch_valid_nxt = r_fetch_valid;
      w_hold_nxt        = r_hold;

      if (branch_taken) begin
         w_state_nxt       = ST_RUN;
         w_pc_nxt          = w_target;
         w_fetch_pc_nxt    = r_pc;
         w_fetch_valid_nxt = REDIRECT_VALID;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (stall) begin
                  w_hold_nxt  = instr_in;
                  w_state_nxt = ST_HOLD;
               end else begin
                  w_fetch_pc_nxt    = r_pc;
                  w_pc_nxt          = w_pc_inc;
                  w_fetch_valid_nxt = 1'b1;
               end
            end
            ST_HOLD: begin
               if (!stall) begin
                  w_fetch_pc_nxt    = r_pc;
                  w_pc_nxt          = w_pc_inc;
                  w_fetch_valid_nxt = 1'b1;
                  w_state_nxt       = ST_RUN;
               end
            end
            default: w_state_nxt = ST_RUN;
         endcase
      end
   end

   // Memory data passes straight through in RUN; HOLD replays the captured word.
   always_comb begin
      if (!r_fetch_valid) begin
         if_id_instr = nop_word;
      end else if (r_state == ST_HOLD) begin
         if_id_instr = r_hold;
      end else begin
         if_id_instr = instr_in;
      end
   end

   assign instr_addr  = r_pc;
   assign if_id_pc    = r_fetch_pc;
   assign if_id_valid = r_fetch_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized stall/branch/reset traffic.
module tb_fetch_stage;

   localparam logic [31:0] PC0 = 32'h80020000;
   localparam logic [31:0] NOP = 32'h00000000;
`ifdef BRANCH_DELAY_SLOT_EN
   localparam logic DS = 1'b1;
`else
   localparam logic DS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] instr_addr;
   logic [31:0] instr_in;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc;
   logic        if_id_valid;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   logic [31:0] m_pc;
   logic [31:0] m_fpc;
   logic        m_fv;

   fetch_stage #(.pc_init(PC0), .nop_word(NOP)) dut (
      .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
      .branch_target(branch_target), .instr_addr(instr_addr), .instr_in(instr_in),
      .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5AC3C3;
   endfunction

   // Synchronous instruction memory with one cycle of read latency.
   always @(posedge clk) instr_in <= mem_word(instr_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: which PC is presented and whether it is real; the word must always be mem[pc].
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_pc  <= PC0;
         m_fpc <= PC0;
         m_fv  <= 1'b0;
      end else if (branch_taken) begin
         m_fpc <= m_pc;
         m_fv  <= DS;
         m_pc  <= branch_target & 32'hFFFFFFFC;
      end else if (!stall) begin
         m_fpc <= m_pc;
         m_pc  <= m_pc + 32'd4;
         m_fv  <= 1'b1;
      end
   end

   always begin
      @(negedge clk);
      #1;
      if (chk_en) begin
         check("model instr_addr", instr_addr, m_pc);
         check("model if_id_pc", if_id_pc, m_fpc);
         check("model if_id_valid", 32'(if_id_valid), 32'(m_fv));
         check("model if_id_instr", if_id_instr, m_fv ? mem_word(m_fpc) : NOP);
      end
   end

   task automatic next();
      @(negedge clk);
      #3;
   endtask

   task automatic chk_reset_vals(input string tag);
      check({tag, " instr_addr"}, instr_addr, PC0);
      check({tag, " if_id_instr"}, if_id_instr, NOP);
      check({tag, " if_id_pc"}, if_id_pc, PC0);
      check({tag, " if_id_valid"}, 32'(if_id_valid), 32'd0);
   endtask

   task automatic chk_out(input string tag, input logic [31:0] addr, input logic [31:0] pc,
                          input logic vld);
      check({tag, " instr_addr"}, instr_addr, addr);
      check({tag, " if_id_pc"}, if_id_pc, pc);
      check({tag, " if_id_valid"}, 32'(if_id_valid), 32'(vld));
      check({tag, " if_id_instr"}, if_id_instr, vld ? mem_word(pc) : NOP);
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
      repeat (2) next();
      chk_reset_vals("in_reset");
      reset  = 1'b0;
      chk_en = 1'b1;
      check("release instr_addr", instr_addr, PC0);
      check("release if_id_valid", 32'(if_id_valid), 32'd0);

      // Straight-line fetch after reset.
      next(); chk_out("seq0", 32'h80020004, 32'h80020000, 1'b1);
      next(); chk_out("seq1", 32'h80020008, 32'h80020004, 1'b1);
      next(); chk_out("seq2", 32'h8002000C, 32'h80020008, 1'b1);

      // Three-cycle stall holds the presented instruction.
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         next(); chk_out("stall", 32'h8002000C, 32'h80020008, 1'b1);
      end
      stall = 1'b0;
      next(); chk_out("unstall", 32'h80020010, 32'h8002000C, 1'b1);

      // Redirect: delay slot at 80020010 is kept or squashed.
      branch_taken = 1'b1; branch_target = 32'h80020040;
      next(); chk_out("branch", 32'h80020040, 32'h80020010, DS);
      branch_taken = 1'b0; branch_target = 32'hDEADBEEF;
      next(); chk_out("post_branch", 32'h80020044, 32'h80020040, 1'b1);

      // Redirect beats stall and leaves the stage running.
      branch_taken = 1'b1; stall = 1'b1; branch_target = 32'h80020100;
      next(); chk_out("br_stall", 32'h80020100, 32'h80020044, DS);
      branch_taken = 1'b0; stall = 1'b0;
      next(); chk_out("br_stall_run", 32'h80020104, 32'h80020100, 1'b1);

      // Target alignment and PC wraparound.
      branch_taken = 1'b1; branch_target = 32'h00000003;
      next(); check("align instr_addr", instr_addr, 32'h00000000);
      branch_target = 32'hFFFFFFFC;
      next(); check("wrap_pre instr_addr", instr_addr, 32'hFFFFFFFC);
      branch_taken = 1'b0;
      next(); chk_out("wrap", 32'h00000000, 32'hFFFFFFFC, 1'b1);

      // Asynchronous reset while holding.
      stall = 1'b1;
      next(); next();
      reset = 1'b1;
      #1;
      chk_reset_vals("async_reset");
      next();
      reset = 1'b0; stall = 1'b0;
      next(); chk_out("after_async", PC0 + 32'd4, PC0, 1'b1);

      // Randomized traffic checked by the reference every cycle.
      for (int i = 0; i < 3000; i++) begin
         next();
         reset        = ($urandom_range(99) == 0);
         stall        = ($urandom_range(9) < 3);
         branch_taken = ($urandom_range(9) == 0);
         if ($urandom_range(3) == 0) branch_target = 32'hFFFFFFF0 | 32'($urandom_range(15));
         else branch_target = $urandom;
      end
      reset = 1'b0; stall = 1'b0; branch_taken = 1'b0;
      next();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
